ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 29 ++
 rtl/ex_if.sv | 39 +++
 rtl/ex_mul_iter.sv | 60 ++++++
 rtl/ex_stage.sv | 132 +++++++++++++
 tb/tb_ex_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, branch codes,
// multiplier FSM encoding and iteration count.
package ex_pkg;

  localparam logic [5:0] OP_PASS = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SHL  = 6'h06;
  localparam logic [5:0] OP_SHR  = 6'h07;
  localparam logic [5:0] OP_SLT  = 6'h08;
  localparam logic [5:0] OP_MUL  = 6'h09;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_EQ     = 2'b01;
  localparam logic [1:0] BR_NE     = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  localparam int MUL_ITERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_if.sv
// ID/EX inputs and EX/MEM plus branch-redirect outputs of the execute stage.
interface ex_if;

  logic [63:0] EX_d0;
  logic [63:0] EX_d1;
  logic [1:0]  EX_br_ctrl;
  logic [4:0]  EX_dest;
  logic [9:0]  EX_br_addr;
  logic [1:0]  EX_tid;
  logic [5:0]  EX_alu_ctrl;
  logic        EX_mem_ctrl;
  logic [1:0]  EX_wb_ctrl;

  logic [63:0] MEM_result;
  logic [63:0] MEM_wdata;
  logic [4:0]  MEM_dest;
  logic        MEM_mem_ctrl;
  logic [1:0]  MEM_wb_ctrl;
  logic [1:0]  MEM_tid;
  logic        br_taken;
  logic [9:0]  br_target;
  logic [1:0]  br_tid;
  logic        ex_stall;

  modport master (
    output EX_d0, EX_d1, EX_br_ctrl, EX_dest, EX_br_addr, EX_tid,
           EX_alu_ctrl, EX_mem_ctrl, EX_wb_ctrl,
    input  MEM_result, MEM_wdata, MEM_dest, MEM_mem_ctrl, MEM_wb_ctrl,
           MEM_tid, br_taken, br_target, br_tid, ex_stall
  );

  modport slave (
    input  EX_d0, EX_d1, EX_br_ctrl, EX_dest, EX_br_addr, EX_tid,
           EX_alu_ctrl, EX_mem_ctrl, EX_wb_ctrl,
    output MEM_result, MEM_wdata, MEM_dest, MEM_mem_ctrl, MEM_wb_ctrl,
           MEM_tid, br_taken, br_target, br_tid, ex_stall
  );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative 64x64 multiplier returning the low 64 product bits; consumes
// 8 bits of B per BUSY cycle, then spends one cycle in DONE.
module ex_mul_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_e  state;
  logic [2:0]  count;
  logic [63:0] a_sh;
  logic [63:0] b_sh;
  logic [63:0] acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            count <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A is pre-shifted, so each partial product lands at its byte weight.
          acc   <= acc + a_sh * {56'd0, b_sh[7:0]};
          a_sh  <= a_sh << 8;
          b_sh  <= b_sh >> 8;
          count <= count + 3'd1;
          if (count == 3'(MUL_ITERS - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU and branch compare into one EX/MEM
// register, with MUL handed to the iterative multiplier under a stall.
module ex_stage
  import ex_pkg::*;
(
  input  logic clk,
  input  logic reset,
  ex_if.slave  ex
);

  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] alu_result;
  logic        br_hit;
  logic        is_mul;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_product;

  logic [63:0] cap_b;
  logic [4:0]  cap_dest;
  logic        cap_mem;
  logic [1:0]  cap_wb;
  logic [1:0]  cap_tid;

  assign op_a      = ex.EX_d0;
  assign op_b      = ex.EX_d1;
  assign is_mul    = (ex.EX_alu_ctrl == OP_MUL);
  // A MUL is accepted only from IDLE; in DONE the still-held MUL is ignored.
  assign mul_start = is_mul && !mul_busy && !mul_done;
  assign ex.ex_stall = !reset && (mul_start || mul_busy);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_result = '0;
    case (ex.EX_alu_ctrl)
      OP_PASS: alu_result = op_a;
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SHL:  alu_result = op_a << op_b[5:0];
      OP_SHR:  alu_result = op_a >> op_b[5:0];
      OP_SLT:  alu_result = {63'd0, $signed(op_a) < $signed(op_b)};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    br_hit = 1'b0;
    case (ex.EX_br_ctrl)
      BR_NONE:   br_hit = 1'b0;
      BR_EQ:     br_hit = (op_a == op_b);
      BR_NE:     br_hit = (op_a != op_b);
      BR_ALWAYS: br_hit = 1'b1;
    endcase
  end

  ex_mul_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex.MEM_result   <= '0;
      ex.MEM_wdata    <= '0;
      ex.MEM_dest     <= '0;
      ex.MEM_mem_ctrl <= 1'b0;
      ex.MEM_wb_ctrl  <= '0;
      ex.MEM_tid      <= '0;
      ex.br_taken     <= 1'b0;
      ex.br_target    <= '0;
      ex.br_tid       <= '0;
      cap_b           <= '0;
      cap_dest        <= '0;
      cap_mem         <= 1'b0;
      cap_wb          <= '0;
      cap_tid         <= '0;
    end else begin
      if (mul_start) begin
        cap_b    <= op_b;
        cap_dest <= ex.EX_dest;
        cap_mem  <= ex.EX_mem_ctrl;
        cap_wb   <= ex.EX_wb_ctrl;
        cap_tid  <= ex.EX_tid;
      end

      if (mul_done) begin
        ex.MEM_result   <= mul_product;
        ex.MEM_wdata    <= cap_b;
        ex.MEM_dest     <= cap_dest;
        ex.MEM_mem_ctrl <= cap_mem;
        ex.MEM_wb_ctrl  <= cap_wb;
        ex.MEM_tid      <= cap_tid;
        ex.br_taken     <= 1'b0;
        ex.br_target    <= '0;
        ex.br_tid       <= '0;
      end else if (mul_start || mul_busy) begin
        ex.MEM_result   <= '0;
        ex.MEM_wdata    <= '0;
        ex.MEM_dest     <= '0;
        ex.MEM_mem_ctrl <= 1'b0;
        ex.MEM_wb_ctrl  <= '0;
        ex.MEM_tid      <= '0;
        ex.br_taken     <= 1'b0;
        ex.br_target    <= '0;
        ex.br_tid       <= '0;
      end else begin
        ex.MEM_result   <= alu_result;
        ex.MEM_wdata    <= op_b;
        ex.MEM_dest     <= ex.EX_dest;
        ex.MEM_mem_ctrl <= ex.EX_mem_ctrl;
        ex.MEM_wb_ctrl  <= ex.EX_wb_ctrl;
        ex.MEM_tid      <= ex.EX_tid;
        ex.br_taken     <= br_hit;
        ex.br_target    <= ex.EX_br_addr;
        ex.br_tid       <= ex.EX_tid;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases, randomized ALU/branch
// traffic and a stalling instruction stream against a behavioural model.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  br;
    logic [4:0]  dest;
    logic [9:0]  addr;
    logic [1:0]  tid;
    logic        mem;
    logic [1:0]  wb;
  } instr_t;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  dest;
    logic [1:0]  wb;
    logic [1:0]  tid;
    logic        taken;
  } exp_t;

  // Reference semantics of each opcode, written as plain arithmetic.
  function automatic logic [63:0] ref_alu(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      6'd0: return a;
      6'd1: return a + b;
      6'd2: return a - b;
      6'd3: return a & b;
      6'd4: return a | b;
      6'd5: return a ^ b;
      6'd6: return a << b[5:0];
      6'd7: return a >> b[5:0];
      6'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      6'd9: return a * b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [5:0] op, input logic [1:0] br, input logic [63:0] a, input logic [63:0] b);
    if (op == 6'd9) return 1'b0;
    case (br)
      2'b01: return a == b;
      2'b10: return a != b;
      2'b11: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic instr_t mk_bubble();
    instr_t i;
    i.op = 6'd0; i.a = '0; i.b = '0; i.br = 2'b00; i.dest = '0;
    i.addr = '0; i.tid = '0; i.mem = 1'b0; i.wb = 2'b00;
    return i;
  endfunction

  function automatic instr_t rand_instr(input bit allow_mul);
    instr_t i;
    int r;
    r = $urandom_range(0, 99);
    if (allow_mul && r < 20) i.op = OP_MUL;
    else if (r < 85)         i.op = 6'($urandom_range(0, 8));
    else                     i.op = 6'($urandom_range(10, 63));
    i.a    = {$urandom, $urandom};
    i.b    = ($urandom_range(0, 3) == 0) ? i.a : {$urandom, $urandom};
    i.br   = 2'($urandom_range(0, 3));
    i.dest = 5'($urandom);
    i.addr = 10'($urandom);
    i.tid  = 2'($urandom);
    i.mem  = 1'($urandom);
    i.wb   = 2'($urandom);
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.EX_alu_ctrl = i.op;
    bus.EX_d0       = i.a;
    bus.EX_d1       = i.b;
    bus.EX_br_ctrl  = i.br;
    bus.EX_dest     = i.dest;
    bus.EX_br_addr  = i.addr;
    bus.EX_tid      = i.tid;
    bus.EX_mem_ctrl = i.mem;
    bus.EX_wb_ctrl  = i.wb;
  endtask

  task automatic test_reset();
    instr_t m;
    logic [150:0] outs;
    m = mk_bubble();
    m.op = OP_MUL; m.a = 64'd3; m.b = 64'd4; m.wb = 2'd1;
    drive(m);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      outs = {bus.MEM_result, bus.MEM_wdata, bus.MEM_dest, bus.MEM_mem_ctrl, bus.MEM_wb_ctrl,
              bus.MEM_tid, bus.br_taken, bus.br_target, bus.br_tid};
      checks++;
      if (bus.ex_stall !== 1'b0) begin
        errors++; $display("FAIL reset_stall[%0d]: got %b expected 0", k, bus.ex_stall);
      end
      checks++;
      if (outs !== '0) begin
        errors++; $display("FAIL reset_outputs[%0d]: got %h expected 0", k, outs);
      end
      @(posedge clk);
    end
    #2;
    drive(mk_bubble());
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    instr_t i;
    i = mk_bubble();
    i.op = OP_ADD; i.a = 64'd5; i.b = 64'd7; i.dest = 5'd3; i.wb = 2'b01;
    drive(i); #1;
    checks++;
    if (bus.ex_stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b expected 0", bus.ex_stall); end
    @(posedge clk); #1;
    checks++;
    if ({bus.MEM_result, bus.MEM_dest, bus.MEM_wb_ctrl} !== {64'd12, 5'd3, 2'b01}) begin
      errors++; $display("FAIL add_5_7: got result=%h dest=%0d wb=%b expected 12/3/01",
                         bus.MEM_result, bus.MEM_dest, bus.MEM_wb_ctrl);
    end

    i = mk_bubble(); i.op = OP_SUB; i.a = 64'd3; i.b = 64'd5; i.wb = 2'b01;
    drive(i); @(posedge clk); #1;
    checks++;
    if (bus.MEM_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL sub_wrap: got %h expected fffffffffffffffe", bus.MEM_result);
    end

    i = mk_bubble(); i.op = OP_SLT; i.a = '1; i.b = 64'd0; i.wb = 2'b01;
    drive(i); @(posedge clk); #1;
    checks++;
    if (bus.MEM_result !== 64'd1) begin
      errors++; $display("FAIL slt_signed: got %h expected 1", bus.MEM_result);
    end

    i = mk_bubble(); i.br = BR_EQ; i.a = 64'd9; i.b = 64'd9; i.addr = 10'h2A; i.tid = 2'd2;
    drive(i); @(posedge clk); #1;
    checks++;
    if ({bus.br_taken, bus.br_target, bus.br_tid} !== {1'b1, 10'h2A, 2'd2}) begin
      errors++; $display("FAIL beq_taken: got taken=%b target=%h tid=%0d expected 1/02a/2",
                         bus.br_taken, bus.br_target, bus.br_tid);
    end

    i.br = BR_NE;
    drive(i); @(posedge clk); #1;
    checks++;
    if (bus.br_taken !== 1'b0) begin
      errors++; $display("FAIL bne_not_taken: got %b expected 0", bus.br_taken);
    end

    i = rand_instr(0); i.br = BR_NONE; i.wb = 2'b00; i.mem = 1'b0;
    drive(i); @(posedge clk); #1;
    checks++;
    if ({bus.MEM_wb_ctrl, bus.MEM_mem_ctrl, bus.br_taken} !== 4'b0) begin
      errors++; $display("FAIL bubble_pass: got wb=%b mem=%b taken=%b expected all 0",
                         bus.MEM_wb_ctrl, bus.MEM_mem_ctrl, bus.br_taken);
    end
  endtask

  task automatic test_random_alu(input int n);
    instr_t i;
    logic [63:0] exp_res;
    for (int k = 0; k < n; k++) begin
      i = rand_instr(0);
      exp_res = ref_alu(i.op, i.a, i.b);
      drive(i); #1;
      checks++;
      if (bus.ex_stall !== 1'b0) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b expected 0", k, bus.ex_stall);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.MEM_result !== exp_res) begin
        errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h",
                           k, i.op, i.a, i.b, bus.MEM_result, exp_res);
      end
      checks++;
      if ({bus.MEM_wdata, bus.MEM_dest, bus.MEM_mem_ctrl, bus.MEM_wb_ctrl, bus.MEM_tid} !==
          {i.b, i.dest, i.mem, i.wb, i.tid}) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got wdata=%h dest=%0d mem=%b wb=%b tid=%0d expected %h/%0d/%b/%b/%0d",
                           k, bus.MEM_wdata, bus.MEM_dest, bus.MEM_mem_ctrl, bus.MEM_wb_ctrl, bus.MEM_tid,
                           i.b, i.dest, i.mem, i.wb, i.tid);
      end
      checks++;
      if ({bus.br_taken, bus.br_target, bus.br_tid} !== {ref_taken(i.op, i.br, i.a, i.b), i.addr, i.tid}) begin
        errors++; $display("FAIL rand_branch[%0d] br=%b: got taken=%b target=%h tid=%0d expected %b/%h/%0d",
                           k, i.br, bus.br_taken, bus.br_target, bus.br_tid,
                           ref_taken(i.op, i.br, i.a, i.b), i.addr, i.tid);
      end
    end
  endtask

  // Presents a MUL at cycle T and follows it through stall, bubbles and result.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b);
    instr_t m;
    logic [63:0] exp_res;
    m = rand_instr(0);
    m.op = OP_MUL; m.a = a; m.b = b; m.wb = 2'($urandom_range(1, 3));
    exp_res = a * b;
    drive(m);
    for (int k = 0; k <= 8; k++) begin
      #1;
      checks++;
      if (bus.ex_stall !== 1'b1) begin
        errors++; $display("FAIL mul_stall T+%0d: got %b expected 1", k, bus.ex_stall);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.MEM_wb_ctrl, bus.MEM_mem_ctrl, bus.br_taken} !== 4'b0) begin
        errors++; $display("FAIL mul_bubble T+%0d: got wb=%b mem=%b taken=%b expected all 0",
                           k + 1, bus.MEM_wb_ctrl, bus.MEM_mem_ctrl, bus.br_taken);
      end
    end
    #1;
    checks++;
    if (bus.ex_stall !== 1'b0) begin
      errors++; $display("FAIL mul_done_stall T+9: got %b expected 0", bus.ex_stall);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.MEM_result, bus.MEM_wdata, bus.MEM_dest, bus.MEM_wb_ctrl, bus.MEM_tid, bus.br_taken} !==
        {exp_res, b, m.dest, m.wb, m.tid, 1'b0}) begin
      errors++; $display("FAIL mul_result a=%h b=%h: got %h dest=%0d wb=%b tid=%0d taken=%b expected %h/%0d/%b/%0d/0",
                         a, b, bus.MEM_result, bus.MEM_dest, bus.MEM_wb_ctrl, bus.MEM_tid, bus.br_taken,
                         exp_res, m.dest, m.wb, m.tid);
    end
    drive(mk_bubble()); #1;
    checks++;
    if (bus.ex_stall !== 1'b0) begin
      errors++; $display("FAIL mul_reaccept_stall: got %b expected 0", bus.ex_stall);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.MEM_wb_ctrl, bus.MEM_mem_ctrl} !== 3'b0) begin
      errors++; $display("FAIL mul_duplicate: got wb=%b mem=%b expected 0", bus.MEM_wb_ctrl, bus.MEM_mem_ctrl);
    end
  endtask

  task automatic test_mul();
    run_mul(64'h0000_0001_0000_0003, 64'd5);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    for (int k = 0; k < 4; k++) run_mul({$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic test_mul_reset();
    instr_t m;
    logic [150:0] outs;
    m = mk_bubble();
    m.op = OP_MUL; m.a = 64'h0000_0001_0000_0003; m.b = 64'd5; m.wb = 2'd1;
    drive(m);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1; #1;
    outs = {bus.MEM_result, bus.MEM_wdata, bus.MEM_dest, bus.MEM_mem_ctrl, bus.MEM_wb_ctrl,
            bus.MEM_tid, bus.br_taken, bus.br_target, bus.br_tid};
    checks++;
    if (bus.ex_stall !== 1'b0) begin
      errors++; $display("FAIL abort_stall: got %b expected 0", bus.ex_stall);
    end
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL abort_outputs: got %h expected 0", outs);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    run_mul(m.a, m.b);
  endtask

  task automatic test_back_to_back();
    instr_t prog[$];
    exp_t   expq[$];
    instr_t i;
    exp_t   e;
    int     head = 0;
    int     cyc = 0;
    logic   stalled;
    for (int k = 0; k < 40; k++) begin
      i = rand_instr(1);
      i.wb = 2'($urandom_range(1, 3));
      prog.push_back(i);
      e.result = ref_alu(i.op, i.a, i.b);
      e.dest   = i.dest;
      e.wb     = i.wb;
      e.tid    = i.tid;
      e.taken  = ref_taken(i.op, i.br, i.a, i.b);
      expq.push_back(e);
    end
    while ((head < prog.size() || expq.size() != 0) && cyc < 800) begin
      if (head < prog.size()) drive(prog[head]);
      else                    drive(mk_bubble());
      #1;
      stalled = bus.ex_stall;
      @(posedge clk); #1;
      if (!stalled && head < prog.size()) head++;
      if (bus.MEM_wb_ctrl != 2'd0 || bus.MEM_mem_ctrl || bus.br_taken) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL stream_extra_output: got result=%h with nothing pending", bus.MEM_result);
        end else begin
          e = expq.pop_front();
          if ({bus.MEM_result, bus.MEM_dest, bus.MEM_wb_ctrl, bus.MEM_tid, bus.br_taken} !==
              {e.result, e.dest, e.wb, e.tid, e.taken}) begin
            errors++; $display("FAIL stream_output: got %h/%0d/%b/%0d/%b expected %h/%0d/%b/%0d/%b",
                               bus.MEM_result, bus.MEM_dest, bus.MEM_wb_ctrl, bus.MEM_tid, bus.br_taken,
                               e.result, e.dest, e.wb, e.tid, e.taken);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL stream_drain: got %0d results missing expected 0", expq.size());
    end
    drive(mk_bubble());
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.MEM_wb_ctrl != 2'd0 || bus.MEM_mem_ctrl || bus.br_taken) begin
        errors++; $display("FAIL stream_tail[%0d]: got wb=%b mem=%b taken=%b expected bubble",
                           k, bus.MEM_wb_ctrl, bus.MEM_mem_ctrl, bus.br_taken);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(mk_bubble());
    test_reset();
    test_directed();
    test_random_alu(150);
    test_mul();
    test_mul_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary within time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
